ts_source_scheduler: RTL and testbench



---
 rtl/qos_sched_pkg.sv | 19 +
 rtl/ts_stream_health.sv | 87 ++++++++
 rtl/ts_source_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_ts_source_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qos_sched_pkg.sv
// ---------------------------------------------------------------------------
// qos_sched_pkg
// Shared definitions for the TS QoS source scheduler:
//   - TS packet length and stream count / index width
//   - scheduler FSM state encoding (as seen on sched_state)
// ---------------------------------------------------------------------------
package qos_sched_pkg;

    localparam int TS_PKT_LEN = 188;
    localparam int N_STREAMS  = 4;
    localparam int IDX_W      = 2;

    typedef enum logic [1:0] {
        ST_NO_SRC = 2'd0,
        ST_ARM    = 2'd1,
        ST_LOCKED = 2'd2
    } sched_state_t;

endpackage

// File: rtl/ts_stream_health.sv
// ---------------------------------------------------------------------------
// ts_stream_health
// Health tracker for one TS stream.
//   - sync cadence timer: cleared on every packet start, saturates at TIMEOUT;
//     the stream is alive while the timer is below TIMEOUT
//   - loss counting over windows of WIN_PKTS packets; the error total of the
//     last completed window is kept in r_err_last
//   - healthy = alive & (last-window errors < cfg_err_thresh), registered
// Ports:
//   clk, rst_n        clock, async active-low reset
//   valid, sync       byte valid and packet-start strobe (sync counts only
//                     when valid is also high)
//   loss_pulse        one-cycle pulse per detected lost packet
//   cfg_err_thresh    unhealthy when last-window errors >= this value
//   healthy           registered health flag
// ---------------------------------------------------------------------------
module ts_stream_health
    import qos_sched_pkg::*;
#(
    parameter int ERR_W    = 8,
    parameter int WIN_PKTS = 64,
    parameter int TIMEOUT  = 10 * TS_PKT_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             sync,
    input  logic             loss_pulse,
    input  logic [ERR_W-1:0] cfg_err_thresh,
    output logic             healthy
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int PKT_W = (WIN_PKTS > 1) ? $clog2(WIN_PKTS) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(WIN_PKTS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [TMR_W-1:0] r_timer;
    logic [PKT_W-1:0] r_pkt_cnt;
    logic [ERR_W-1:0] r_err_cnt;
    logic [ERR_W-1:0] r_err_last;
    logic             r_healthy;

    logic             w_pkt;
    logic             w_alive;
    logic [ERR_W-1:0] w_err_inc;

    assign w_pkt   = sync & valid;
    assign w_alive = (r_timer < TMR_MAX);

    // Error count including this cycle's loss pulse, so a loss landing on the
    // window-closing packet is still charged to the closing window.
    assign w_err_inc = (loss_pulse && (r_err_cnt != ERR_MAX)) ? r_err_cnt + 1'b1 : r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer    <= TMR_MAX;
            r_pkt_cnt  <= '0;
            r_err_cnt  <= '0;
            r_err_last <= '0;
            r_healthy  <= 1'b0;
        end else begin
            if (w_pkt) begin
                r_timer <= '0;
            end else if (r_timer != TMR_MAX) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_pkt && (r_pkt_cnt == PKT_LAST)) begin
                r_err_last <= w_err_inc;
                r_err_cnt  <= '0;
                r_pkt_cnt  <= '0;
            end else begin
                r_err_cnt <= w_err_inc;
                if (w_pkt) begin
                    r_pkt_cnt <= r_pkt_cnt + 1'b1;
                end
            end

            r_healthy <= w_alive && (r_err_last < cfg_err_thresh);
        end
    end

    assign healthy = r_healthy;

endmodule

// File: rtl/ts_source_scheduler.sv
// ---------------------------------------------------------------------------
// ts_source_scheduler
// Packet-aligned source selector for four TS streams. Tracks per-stream
// health, picks a candidate (auto: lowest-index healthy stream; manual:
// cfg_manual_sel) and only moves the output mux on a packet start of the
// target stream, so no packet is ever truncated.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   valid[3:0]          per-stream byte valid
//   sync[3:0]           per-stream packet start; a packet start is
//                       sync[i] & valid[i] in the same cycle, sync alone is
//                       ignored
//   loss_pulse[3:0]     per-stream lost-packet pulses
//   cfg_auto            1 = priority failover, 0 = manual
//   cfg_manual_sel      stream forced in manual mode
//   cfg_err_thresh      per-window error threshold for health
//   mux_control         committed stream index
//   sel_valid           mux_control carries a usable stream
//   switch_pulse        one cycle per commit
//   healthy[3:0]        per-stream health flags
//   sched_state         FSM state (0 NO_SRC, 1 ARM, 2 LOCKED)
//   switch_count        commits since reset, saturating
// ---------------------------------------------------------------------------
module ts_source_scheduler
    import qos_sched_pkg::*;
#(
    parameter int ERR_W        = 8,
    parameter int WIN_PKTS     = 64,
    parameter int TIMEOUT      = 10 * TS_PKT_LEN,
    parameter int HOLDOFF_PKTS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_STREAMS-1:0] valid,
    input  logic [N_STREAMS-1:0] sync,
    input  logic [N_STREAMS-1:0] loss_pulse,
    input  logic                 cfg_auto,
    input  logic [IDX_W-1:0]     cfg_manual_sel,
    input  logic [ERR_W-1:0]     cfg_err_thresh,
    output logic [IDX_W-1:0]     mux_control,
    output logic                 sel_valid,
    output logic                 switch_pulse,
    output logic [N_STREAMS-1:0] healthy,
    output logic [1:0]           sched_state,
    output logic [15:0]          switch_count
);

    localparam int HOLD_W = $clog2(HOLDOFF_PKTS + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_PKTS);

    sched_state_t       r_state,  w_state_nx;
    logic [IDX_W-1:0]   r_mux,    w_mux_nx;
    logic [IDX_W-1:0]   r_target, w_target_nx;
    logic               r_keep_old, w_keep_nx;
    logic [HOLD_W-1:0]  r_holdoff, w_hold_nx;
    logic               r_switch_pulse;
    logic [15:0]        r_switch_count;

    logic [N_STREAMS-1:0] w_healthy;
    logic [N_STREAMS-1:0] w_pkt;
    logic                 w_cand_ok;
    logic [IDX_W-1:0]     w_cand;
    logic                 w_commit;
    logic                 w_sel_valid;

    for (genvar gi = 0; gi < N_STREAMS; gi++) begin : g_health
        ts_stream_health #(
            .ERR_W    (ERR_W),
            .WIN_PKTS (WIN_PKTS),
            .TIMEOUT  (TIMEOUT)
        ) u_health (
            .clk            (clk),
            .rst_n          (rst_n),
            .valid          (valid[gi]),
            .sync           (sync[gi]),
            .loss_pulse     (loss_pulse[gi]),
            .cfg_err_thresh (cfg_err_thresh),
            .healthy        (w_healthy[gi])
        );
    end

    assign w_pkt = sync & valid;

    // Candidate: downward scan so the lowest healthy index wins.
    always_comb begin
        w_cand_ok = 1'b0;
        w_cand    = '0;
        if (cfg_auto) begin
            for (int i = N_STREAMS - 1; i >= 0; i--) begin
                if (w_healthy[i]) begin
                    w_cand_ok = 1'b1;
                    w_cand    = IDX_W'(i);
                end
            end
        end else begin
            w_cand_ok = 1'b1;
            w_cand    = cfg_manual_sel;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_mux_nx    = r_mux;
        w_target_nx = r_target;
        w_keep_nx   = r_keep_old;
        w_hold_nx   = r_holdoff;
        w_commit    = 1'b0;
        w_sel_valid = 1'b0;
        case (r_state)
            ST_NO_SRC: begin
                if (w_cand_ok) begin
                    w_target_nx = w_cand;
                    w_keep_nx   = 1'b0;
                    w_state_nx  = ST_ARM;
                end
            end
            ST_ARM: begin
                // While re-arming from a locked stream, keep flagging the old
                // stream as usable as long as it still is.
                w_sel_valid = r_keep_old & (cfg_auto ? w_healthy[r_mux] : 1'b1);
                if (!w_cand_ok) begin
                    w_state_nx = ST_NO_SRC;
                end else if (w_pkt[r_target]) begin
                    // The registered target commits even if the candidate
                    // moves in this same cycle.
                    w_commit   = 1'b1;
                    w_mux_nx   = r_target;
                    w_hold_nx  = HOLD_INIT;
                    w_state_nx = ST_LOCKED;
                end else begin
                    w_target_nx = w_cand;
                end
            end
            ST_LOCKED: begin
                w_sel_valid = 1'b1;
                if (w_pkt[r_mux] && (r_holdoff != '0)) begin
                    w_hold_nx = r_holdoff - 1'b1;
                end
                if (cfg_auto) begin
                    if (!w_healthy[r_mux]) begin
                        w_target_nx = w_cand;
                        w_keep_nx   = 1'b0;
                        w_state_nx  = ST_ARM;
                    end else if ((w_cand != r_mux) && (r_holdoff == '0)) begin
                        w_target_nx = w_cand;
                        w_keep_nx   = 1'b1;
                        w_state_nx  = ST_ARM;
                    end
                end else if (cfg_manual_sel != r_mux) begin
                    w_target_nx = cfg_manual_sel;
                    w_keep_nx   = 1'b1;
                    w_state_nx  = ST_ARM;
                end
            end
            default: begin
                w_state_nx = ST_NO_SRC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_NO_SRC;
            r_mux          <= '0;
            r_target       <= '0;
            r_keep_old     <= 1'b0;
            r_holdoff      <= '0;
            r_switch_pulse <= 1'b0;
            r_switch_count <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_mux          <= w_mux_nx;
            r_target       <= w_target_nx;
            r_keep_old     <= w_keep_nx;
            r_holdoff      <= w_hold_nx;
            r_switch_pulse <= w_commit;
            if (w_commit && (r_switch_count != 16'hFFFF)) begin
                r_switch_count <= r_switch_count + 16'd1;
            end
        end
    end

    assign mux_control  = r_mux;
    assign sel_valid    = w_sel_valid;
    assign switch_pulse = r_switch_pulse;
    assign healthy      = w_healthy;
    assign sched_state  = r_state;
    assign switch_count = r_switch_count;

endmodule

// File: tb/tb_ts_source_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ts_source_scheduler
// Directed scenario sequence with randomized stream jitter/noise, followed by
// a randomized configuration phase. A reference model computed from stream
// event history (last packet time, per-window loss totals) and the selection
// rules predicts every cycle's outputs; commits are pushed to exp_q and popped
// by the monitor whenever the DUT raises switch_pulse.
// ---------------------------------------------------------------------------
module tb_ts_source_scheduler;

    localparam int ERR_W        = 8;
    localparam int WIN_PKTS     = 64;
    localparam int TIMEOUT      = 1880;
    localparam int HOLDOFF_PKTS = 4;
    localparam int PER          = 188;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid, sync, loss_pulse;
    logic        cfg_auto;
    logic [1:0]  cfg_manual_sel;
    logic [7:0]  cfg_err_thresh;
    logic [1:0]  mux_control;
    logic        sel_valid;
    logic        switch_pulse;
    logic [3:0]  healthy;
    logic [1:0]  sched_state;
    logic [15:0] switch_count;

    ts_source_scheduler #(
        .ERR_W        (ERR_W),
        .WIN_PKTS     (WIN_PKTS),
        .TIMEOUT      (TIMEOUT),
        .HOLDOFF_PKTS (HOLDOFF_PKTS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid          (valid),
        .sync           (sync),
        .loss_pulse     (loss_pulse),
        .cfg_auto       (cfg_auto),
        .cfg_manual_sel (cfg_manual_sel),
        .cfg_err_thresh (cfg_err_thresh),
        .mux_control    (mux_control),
        .sel_valid      (sel_valid),
        .switch_pulse   (switch_pulse),
        .healthy        (healthy),
        .sched_state    (sched_state),
        .switch_count   (switch_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard bookkeeping ----------------
    int          n_cmp;
    int          n_err;
    logic [17:0] exp_q[$];   // {committed index, switch_count after commit}
    logic [17:0] exp_item;
    logic [25:0] mon_exp, mon_got;

    // ---------------- stimulus controls ----------------
    int s_cnt[4];
    bit s_en[4];
    int s_loss_req[4];
    int s_loss_rate;     // per 10000 cycles, random phase only

    // ---------------- reference model ----------------
    int cyc;
    int m_last[4];       // cycle of last packet start
    int m_wpk[4];        // packets seen in current window
    int m_werr[4];       // losses in current window
    int m_elast[4];      // losses of last completed window
    bit m_h[4];
    int m_state;         // 0 no source, 1 arming, 2 locked
    int m_mux, m_target, m_hold, m_count;
    bit m_keep, m_pulse;

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            m_last[i]  = -2 * TIMEOUT;
            m_wpk[i]   = 0;
            m_werr[i]  = 0;
            m_elast[i] = 0;
            m_h[i]     = 0;
        end
        m_state = 0; m_mux = 0; m_target = 0; m_hold = 0; m_count = 0;
        m_keep = 0; m_pulse = 0;
    endtask

    function automatic bit exp_sel();
        if (m_state == 2) return 1'b1;
        if (m_state == 1) return m_keep && (cfg_auto ? m_h[m_mux] : 1'b1);
        return 1'b0;
    endfunction

    // Advances the model across one rising edge using the inputs the DUT samples.
    task automatic model_step();
        bit pkt[4];
        bit new_h[4];
        bit cand_ok;
        int cand;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc++;
        for (int i = 0; i < 4; i++) pkt[i] = sync[i] & valid[i];
        cand_ok = 0;
        cand    = 0;
        if (cfg_auto) begin
            for (int i = 0; i < 4; i++) begin
                if (m_h[i] && !cand_ok) begin
                    cand_ok = 1;
                    cand    = i;
                end
            end
        end else begin
            cand_ok = 1;
            cand    = cfg_manual_sel;
        end

        m_pulse = 0;
        if (m_state == 0) begin
            if (cand_ok) begin
                m_target = cand; m_keep = 0; m_state = 1;
            end
        end else if (m_state == 1) begin
            if (!cand_ok) begin
                m_state = 0;
            end else if (pkt[m_target]) begin
                m_mux   = m_target;
                m_hold  = HOLDOFF_PKTS;
                m_state = 2;
                m_pulse = 1;
                if (m_count < 65535) m_count++;
                exp_q.push_back({2'(m_mux), 16'(m_count)});
            end else begin
                m_target = cand;
            end
        end else begin
            int hold_before;
            hold_before = m_hold;
            if (pkt[m_mux] && m_hold > 0) m_hold--;
            if (cfg_auto) begin
                if (!m_h[m_mux]) begin
                    m_target = cand; m_keep = 0; m_state = 1;
                end else if (cand != m_mux && hold_before == 0) begin
                    m_target = cand; m_keep = 1; m_state = 1;
                end
            end else if (int'(cfg_manual_sel) != m_mux) begin
                m_target = cfg_manual_sel; m_keep = 1; m_state = 1;
            end
        end

        // Health visible after this edge is judged on the cadence and window
        // totals as they stood before this edge.
        for (int i = 0; i < 4; i++) begin
            new_h[i] = ((cyc - 1 - m_last[i]) < TIMEOUT) && (m_elast[i] < int'(cfg_err_thresh));
            if (loss_pulse[i] && m_werr[i] < 255) m_werr[i]++;
            if (pkt[i]) begin
                m_last[i] = cyc;
                m_wpk[i]++;
                if (m_wpk[i] == WIN_PKTS) begin
                    m_elast[i] = m_werr[i];
                    m_werr[i]  = 0;
                    m_wpk[i]   = 0;
                end
            end
            m_h[i] = new_h[i];
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_next();
        for (int i = 0; i < 4; i++) begin
            bit v, s, l;
            v = ($urandom_range(0, 9) != 0);
            s = 1'b0;
            l = 1'b0;
            if (s_cnt[i] == 0) begin
                s_cnt[i] = PER - 1;
                if (s_en[i]) begin
                    v = 1'b1;
                    s = 1'b1;
                end
            end else begin
                s_cnt[i]--;
                if (!v && $urandom_range(0, 15) == 0) s = 1'b1;  // unqualified strobe
            end
            // Losses only well away from packet starts, so a burst stays in one window.
            if (s_cnt[i] > 20 && s_cnt[i] < PER - 20) begin
                if (s_loss_req[i] > 0) begin
                    l = 1'b1;
                    s_loss_req[i]--;
                end else if ($urandom_range(0, 9999) < s_loss_rate) begin
                    l = 1'b1;
                end
            end
            valid[i]      = v;
            sync[i]       = s;
            loss_pulse[i] = l;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            drive_next();
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        mon_exp = {m_h[3], m_h[2], m_h[1], m_h[0], 2'(m_state), 2'(m_mux),
                   exp_sel(), m_pulse, 16'(m_count)};
        mon_got = {healthy, sched_state, mux_control, sel_valid, switch_pulse, switch_count};
        check("cycle_outputs{healthy,state,mux,sel,pulse,count}", 32'(mon_got), 32'(mon_exp));
        if (switch_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL commit: unexpected switch_pulse mux=%0d count=%0d, none expected (t=%0t)",
                         mux_control, switch_count, $time);
            end else begin
                exp_item = exp_q.pop_front();
                check("commit{mux,count}", 32'({mux_control, switch_count}), 32'(exp_item));
            end
        end
    end

    // ---------------- main sequence ----------------
    bit got_arm;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        valid = '0; sync = '0; loss_pulse = '0;
        cfg_auto = 1'b1; cfg_manual_sel = 2'd0; cfg_err_thresh = 8'd3;
        s_loss_rate = 0;
        s_cnt[0] = 10;
        for (int i = 1; i < 4; i++) s_cnt[i] = $urandom_range(20, PER - 1);
        for (int i = 0; i < 4; i++) begin
            s_en[i] = 1'b1;
            s_loss_req[i] = 0;
        end
        model_reset();

        // Reset values
        run(4);
        @(negedge clk);
        check("reset_outputs", 32'({healthy, sched_state, mux_control, sel_valid, switch_pulse, switch_count}), 32'd0);
        run(1);
        rst_n = 1'b1;

        // All streams running, auto: lock onto stream 0
        run(800);
        @(negedge clk);
        check("all_healthy", 32'(healthy), 32'hF);
        check("lock0_mux", 32'(mux_control), 32'd0);
        check("lock0_count", 32'(switch_count), 32'd1);
        check("lock0_sel", 32'(sel_valid), 32'd1);

        // Stream 0 goes silent: failover to stream 1
        s_en[0] = 1'b0;
        run(2300);
        @(negedge clk);
        check("dead0_healthy0", 32'(healthy[0]), 32'd0);
        check("fail1_mux", 32'(mux_control), 32'd1);
        check("fail1_count", 32'(switch_count), 32'd2);

        // Stream 0 back: preempt after holdoff
        s_en[0] = 1'b1;
        run(2000);
        @(negedge clk);
        check("preempt0_mux", 32'(mux_control), 32'd0);
        check("preempt0_count", 32'(switch_count), 32'd3);

        // 3 losses on stream 0 (fails at window end), 2 on stream 1 (stays healthy)
        s_loss_req[0] = 3;
        s_loss_req[1] = 2;
        run(25000);
        @(negedge clk);
        check("loss_cycle_mux", 32'(mux_control), 32'd0);
        check("loss_cycle_count", 32'(switch_count), 32'd5);

        // Zero threshold: nothing healthy
        cfg_err_thresh = 8'd0;
        run(300);
        @(negedge clk);
        check("thr0_healthy", 32'(healthy), 32'd0);
        check("thr0_state", 32'(sched_state), 32'd0);
        check("thr0_sel", 32'(sel_valid), 32'd0);
        cfg_err_thresh = 8'd3;
        run(600);
        @(negedge clk);
        check("relock_mux", 32'(mux_control), 32'd0);
        check("relock_count", 32'(switch_count), 32'd6);

        // Manual select of a dead stream, then it starts
        s_en[2] = 1'b0;
        run(2000);
        cfg_auto = 1'b0;
        cfg_manual_sel = 2'd2;
        run(500);
        @(negedge clk);
        check("man_wait_healthy2", 32'(healthy[2]), 32'd0);
        check("man_wait_state", 32'(sched_state), 32'd1);
        check("man_wait_sel", 32'(sel_valid), 32'd1);
        check("man_wait_mux", 32'(mux_control), 32'd0);
        s_en[2] = 1'b1;
        run(400);
        @(negedge clk);
        check("man_lock_mux", 32'(mux_control), 32'd2);
        check("man_lock_count", 32'(switch_count), 32'd7);

        // Reset while arming
        s_en[3] = 1'b0;
        cfg_manual_sel = 2'd3;
        got_arm = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            model_step();
            #1;
            if (m_state == 1) begin
                got_arm = 1'b1;
                rst_n = 1'b0;
                model_reset();
            end
            drive_next();
            if (got_arm) break;
        end
        n_cmp++;
        if (!got_arm) begin
            n_err++;
            $display("FAIL arm_wait: no arming within 20 cycles, state=%0d", sched_state);
            rst_n = 1'b0;
            model_reset();
        end
        #1;
        check("async_reset_outputs", 32'({healthy, sched_state, mux_control, sel_valid, switch_pulse, switch_count}), 32'd0);
        run(3);
        rst_n = 1'b1;
        run(300);
        @(negedge clk);
        check("post_reset_count", 32'(switch_count), 32'd0);
        check("post_reset_state", 32'(sched_state), 32'd1);
        s_en[3] = 1'b1;
        cfg_auto = 1'b1;

        // Randomized configuration phase
        s_loss_rate = 2;
        for (int blk = 0; blk < 30; blk++) begin
            cfg_auto       = ($urandom_range(0, 3) != 0);
            cfg_manual_sel = 2'($urandom_range(0, 3));
            cfg_err_thresh = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) s_en[i] = ($urandom_range(0, 3) != 0);
            run(500);
        end

        run(5);
        @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
